// File: rtl/axi_ram_resp.sv
`default_nettype none
// ============================================================================
// Module   : axi_ram_resp
// Purpose  : AXI4 responder backed by a single-port synchronous word RAM.
//            One transaction at a time, INCR bursts of up to 256 full-width
//            beats, round-robin arbitration between write and read channels.
// Revision : 1.0 - initial release
// ============================================================================
module axi_ram_resp #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int MEM_ADDR_W = 16,
   parameter int ID_W       = 1
) (
   input  logic                clk,
   input  logic                rst,
   // write address channel
   input  logic [ID_W-1:0]     axi_awid,
   input  logic [ADDR_W-1:0]   axi_awaddr,
   input  logic [7:0]          axi_awlen,
   input  logic [2:0]          axi_awsize,
   input  logic [1:0]          axi_awburst,
   input  logic                axi_awlock,
   input  logic [3:0]          axi_awcache,
   input  logic [2:0]          axi_awprot,
   input  logic [3:0]          axi_awqos,
   input  logic                axi_awvalid,
   output logic                axi_awready,
   // write data channel
   input  logic [DATA_W-1:0]   axi_wdata,
   input  logic [DATA_W/8-1:0] axi_wstrb,
   input  logic                axi_wlast,
   input  logic                axi_wvalid,
   output logic                axi_wready,
   // write response channel
   output logic [ID_W-1:0]     axi_bid,
   output logic [1:0]          axi_bresp,
   output logic                axi_bvalid,
   input  logic                axi_bready,
   // read address channel
   input  logic [ID_W-1:0]     axi_arid,
   input  logic [ADDR_W-1:0]   axi_araddr,
   input  logic [7:0]          axi_arlen,
   input  logic [2:0]          axi_arsize,
   input  logic [1:0]          axi_arburst,
   input  logic                axi_arlock,
   input  logic [3:0]          axi_arcache,
   input  logic [2:0]          axi_arprot,
   input  logic [3:0]          axi_arqos,
   input  logic                axi_arvalid,
   output logic                axi_arready,
   // read data channel
   output logic [ID_W-1:0]     axi_rid,
   output logic [DATA_W-1:0]   axi_rdata,
   output logic [1:0]          axi_rresp,
   output logic                axi_rlast,
   output logic                axi_rvalid,
   input  logic                axi_rready
);

   localparam int STRB_W = DATA_W / 8;
   localparam int OFF_W  = $clog2(STRB_W);
   localparam int DEPTH  = 1 << MEM_ADDR_W;

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_AW_ACK = 3'd1;
   localparam logic [2:0] S_WDATA  = 3'd2;
   localparam logic [2:0] S_WRESP  = 3'd3;
   localparam logic [2:0] S_AR_ACK = 3'd4;
   localparam logic [2:0] S_RLOAD  = 3'd5;
   localparam logic [2:0] S_RDATA  = 3'd6;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   logic [2:0]            state_q,   state_d;
   logic                  last_rd_q, last_rd_d;   // 1: read channel was granted last
   logic [ID_W-1:0]       id_q,      id_d;
   logic [MEM_ADDR_W-1:0] word_q,    word_d;
   logic [7:0]            len_q,     len_d;
   logic [7:0]            count_q,   count_d;
   logic                  err_q,     err_d;        // sticky WLAST-mismatch flag
   logic [DATA_W-1:0]     rdata_q;

   logic [DATA_W-1:0]     mem [0:DEPTH-1];

   logic                  w_mem_we;
   logic                  w_mem_re;
   logic [MEM_ADDR_W-1:0] w_mem_addr;
   logic                  w_last_beat;
   logic [MEM_ADDR_W-1:0] w_aw_word;
   logic [MEM_ADDR_W-1:0] w_ar_word;

   // Sideband fields, unused address bits, size and burst type carry no meaning here
   logic unused_inputs;
   assign unused_inputs = ^{axi_awaddr, axi_awsize, axi_awburst, axi_awlock, axi_awcache,
                            axi_awprot, axi_awqos, axi_araddr, axi_arsize, axi_arburst,
                            axi_arlock, axi_arcache, axi_arprot, axi_arqos};

   assign w_aw_word   = axi_awaddr[MEM_ADDR_W+OFF_W-1:OFF_W];
   assign w_ar_word   = axi_araddr[MEM_ADDR_W+OFF_W-1:OFF_W];
   assign w_last_beat = (count_q == len_q);

   // State and transaction-context registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         last_rd_q <= 1'b1;
         id_q      <= '0;
         word_q    <= '0;
         len_q     <= '0;
         count_q   <= '0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         last_rd_q <= last_rd_d;
         id_q      <= id_d;
         word_q    <= word_d;
         len_q     <= len_d;
         count_q   <= count_d;
         err_q     <= err_d;
      end
   end

   // Next-state, arbitration, burst bookkeeping and RAM port control
   always_comb begin
      state_d    = state_q;
      last_rd_d  = last_rd_q;
      id_d       = id_q;
      word_d     = word_q;
      len_d      = len_q;
      count_d    = count_q;
      err_d      = err_q;
      w_mem_we   = 1'b0;
      w_mem_re   = 1'b0;
      w_mem_addr = word_q;
      case (state_q)
         S_IDLE: begin
            // on a tie the channel not granted last wins
            if (axi_awvalid && (!axi_arvalid || last_rd_q)) begin
               state_d   = S_AW_ACK;
               last_rd_d = 1'b0;
            end else if (axi_arvalid) begin
               state_d   = S_AR_ACK;
               last_rd_d = 1'b1;
            end
         end
         S_AW_ACK: begin
            id_d    = axi_awid;
            word_d  = w_aw_word;
            len_d   = axi_awlen;
            count_d = '0;
            err_d   = 1'b0;
            state_d = S_WDATA;
         end
         S_WDATA: begin
            if (axi_wvalid) begin
               w_mem_we = 1'b1;
               word_d   = word_q + 1'b1;
               count_d  = count_q + 8'd1;
               if (axi_wlast != w_last_beat) begin
                  err_d = 1'b1;
               end
               if (w_last_beat) begin
                  state_d = S_WRESP;
               end
            end
         end
         S_WRESP: begin
            if (axi_bready) begin
               state_d = S_IDLE;
            end
         end
         S_AR_ACK: begin
            id_d    = axi_arid;
            word_d  = w_ar_word;
            len_d   = axi_arlen;
            count_d = '0;
            state_d = S_RLOAD;
         end
         S_RLOAD: begin
            w_mem_re = 1'b1;
            state_d  = S_RDATA;
         end
         S_RDATA: begin
            // prefetch the next word only when the current beat is taken,
            // so the data register holds steady under backpressure
            w_mem_re = 1'b1;
            if (axi_rready) begin
               w_mem_addr = word_q + 1'b1;
               word_d     = word_q + 1'b1;
               count_d    = count_q + 8'd1;
               if (w_last_beat) begin
                  state_d = S_IDLE;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Channel outputs decoded from the registered state
   always_comb begin
      axi_awready = (state_q == S_AW_ACK);
      axi_wready  = (state_q == S_WDATA);
      axi_bvalid  = (state_q == S_WRESP);
      axi_bid     = (state_q == S_WRESP) ? id_q : '0;
      axi_bresp   = ((state_q == S_WRESP) && err_q) ? RESP_SLVERR : RESP_OKAY;
      axi_arready = (state_q == S_AR_ACK);
      axi_rvalid  = (state_q == S_RDATA);
      axi_rid     = (state_q == S_RDATA) ? id_q : '0;
      axi_rresp   = RESP_OKAY;
      axi_rlast   = (state_q == S_RDATA) && w_last_beat;
      axi_rdata   = rdata_q;
   end

   // RAM write port with per-byte enables; contents are never reset
   always_ff @(posedge clk) begin
      if (w_mem_we) begin
         for (int b = 0; b < STRB_W; b++) begin
            if (axi_wstrb[b]) begin
               mem[w_mem_addr][b*8 +: 8] <= axi_wdata[b*8 +: 8];
            end
         end
      end
   end

   // RAM read data register, cleared by reset so RDATA starts at zero
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdata_q <= '0;
      end else if (w_mem_re) begin
         rdata_q <= mem[w_mem_addr];
      end
   end

endmodule
`default_nettype wire
